spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parameterised SPI master, the successor to the fixed 8-bit SPI block.
- Configurable word width, SCLK divider and bit order; SPI mode (CPOL/CPHA) is chosen at run time, per word.
- Sits between user logic, via a valid/ready word interface, and the tt_um pin wrapper (sclk, mosi, cs_n on uo_out; miso on ui_in).
- Full-duplex: one word is shifted out and one word is captured per transfer.

Parameters:
- DATA_W, 8, bits per transfer; legal range 2 to 32.
- CLK_DIV, 4, system clocks per SCLK half-period; must be at least 1.
- LSB_FIRST, 0, bit order. 0 means MSB first; 1 means LSB first, on both mosi and miso.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpol  in  1  SCLK idle level; latched when a word is accepted.
- cpha  in  1  0: sample on the leading edge. 1: sample on the trailing edge. Latched when a word is accepted.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  request to start a transfer.
- tx_ready  out  1  high when idle; a transfer starts on any cycle with tx_valid and tx_ready both high.
- rx_data  out  DATA_W  last received word; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high from the cycle after accept until transfer end.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in; sampled directly, synchronisers live in the wrapper.
- cs_n  out  1  chip select, active-low.

Behaviour:
- Reset values: tx_ready=1, busy=0, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0. Reset returns the FSM to IDLE immediately from any state.
- Reset mid-transfer: cs_n rises asynchronously, the partial word is discarded and no rx_valid pulse is produced.
- Divider: counter runs 0 to CLK_DIV-1 in every non-IDLE state. A tick fires when the counter equals CLK_DIV-1, then the counter wraps to 0. The counter is cleared on accept.
- IDLE state:
  - tx_ready=1 and sclk follows the cpol input.
  - On accept: latch tx_data into the shift register, latch cpol/cpha, go to LEAD.
- LEAD state (1 half-period):
  - cs_n=0 and sclk=cpol.
  - For cpha=0, mosi presents the first bit.
  - On tick, go to XFER with edge index e=0.
- XFER state (2*DATA_W half-periods):
  - Each tick toggles sclk and increments e. Even e is a leading edge; odd e is a trailing edge.
  - cpha=0: sample miso on leading edges; shift the next bit out on trailing edges, except the final one.
  - cpha=1: shift the next bit out on leading edges (the first leading edge presents the first bit); sample miso on trailing edges.
  - After e=2*DATA_W-1, sclk is back at cpol; go to TRAIL.
- TRAIL state (1 half-period):
  - cs_n stays 0 and sclk=cpol.
  - On tick, go to IDLE, set cs_n=1, load rx_data and pulse rx_valid.
- Timing:
  - cs_n is low for exactly (2*DATA_W+2)*CLK_DIV cycles, starting the cycle after accept.
  - rx_valid, tx_ready=1 and cs_n=1 all appear in the same cycle.
  - busy equals the inverse of tx_ready.
- Back-to-back: if tx_valid is high when IDLE is re-entered, the next word is accepted that cycle. cs_n is high for at least 1 cycle between words.
- Input stability:
  - tx_valid, tx_data, cpol and cpha are ignored while busy.
  - Changing cpol/cpha mid-transfer has no effect.
  - In IDLE, sclk tracks cpol one cycle late, since sclk is registered.
- Bit order: the shift register shifts left for MSB-first and right for LSB-first. Received bits enter at the opposite end, so rx_data has the same bit significance as tx_data.
- mosi is registered and glitch-free. When cs_n=1, mosi holds the last driven bit; bench checks it only while cs_n=0.

Test Plan:
- Mode 0 loopback (DATA_W=8, CLK_DIV=2, miso tied to mosi, cpol=0, cpha=0, tx_data=0xA9):
  - cs_n low for 36 cycles.
  - 8 rising sclk edges.
  - mosi bits 1,0,1,0,1,0,0,1 at the rising edges.
  - rx_valid pulse with rx_data=0xA9.
- Modes 1/2/3 against a bench SPI slave model returning 0x5C (DATA_W=8, tx_data=0x3E):
  - slave receives 0x3E and rx_data=0x5C in every mode.
  - sclk idles at cpol before and after each transfer.
- LSB-first wide word (DATA_W=16, LSB_FIRST=1, CLK_DIV=1, tx_data=0x8001, loopback):
  - first mosi bit is 1, followed by 14 zeros and a final 1.
  - cs_n low for 34 cycles; rx_data=0x8001.
- Back-to-back (tx_valid held high, words 0x12 then 0x34):
  - two rx_valid pulses, rx_data 0x12 then 0x34.
  - cs_n high for exactly 1 cycle between words.
  - tx_valid pulses issued while busy start no extra transfer.
- Reset mid-transfer (assert rst during XFER at e=5):
  - cs_n=1, sclk=0 and tx_ready=1 asynchronously.
  - no rx_valid pulse.
  - a subsequent transfer of 0xC3 completes correctly.

Source files
------------

// File: rtl/spi_master_param.sv
// spi_master_param: full-duplex SPI master with configurable width, divider and bit order.
// CPOL/CPHA are captured per word at accept; all outputs are registered.
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0] E_LAST = EW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EW-1:0]     e_q, e_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_sh_nx, rx_sh_nx;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d, rx_valid_q, rx_valid_d;
    logic              tick;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    assign tick     = cnt_q == CNT_MAX;
    assign tx_sh_nx = LSB_FIRST ? tx_sh_q >> 1 : tx_sh_q << 1;
    // received bits enter opposite the transmit end so rx_data keeps tx_data significance
    assign rx_sh_nx = LSB_FIRST ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};

    always_comb begin
        state_d    = state_q;
        cnt_d      = (state_q == IDLE) ? cnt_q : (tick ? '0 : cnt_q + CW'(1));
        e_d        = e_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (tx_valid) begin
                    state_d = LEAD;
                    cnt_d   = '0;
                    tx_sh_d = tx_data;
                    rx_sh_d = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    cs_n_d  = 1'b0;
                    mosi_d  = cpha ? mosi_q : first_bit(tx_data);
                end
            end
            LEAD: begin
                sclk_d = cpol_q;
                if (tick) begin
                    state_d = XFER;
                    e_d     = '0;
                end
            end
            XFER: begin
                if (tick) begin
                    sclk_d = !sclk_q;
                    e_d    = e_q + EW'(1);
                    // even e is a leading edge: sample there for cpha=0, on odd e for cpha=1
                    if (e_q[0] == cpha_q) begin
                        rx_sh_d = rx_sh_nx;
                    end else if (cpha_q || e_q != E_LAST) begin
                        tx_sh_d = tx_sh_nx;
                        mosi_d  = cpha_q ? first_bit(tx_sh_q) : first_bit(tx_sh_nx);
                    end
                    if (e_q == E_LAST) state_d = TRAIL;
                end
            end
            default: begin
                sclk_d = cpol_q;
                if (tick) begin
                    state_d    = IDLE;
                    cs_n_d     = 1'b1;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            e_q        <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            e_q        <= e_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = state_q == IDLE;
    assign busy     = !tx_ready;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: two instances (8-bit MSB-first /2, 16-bit LSB-first /1) checked
// against an edge-level SPI slave model and bus monitors.
module tb_spi_master_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       a_cpol = 1'b0, a_cpha = 1'b0, a_tx_valid = 1'b0, loop_a = 1'b1, slave_miso = 1'b0;
    logic [7:0] a_tx_data = 8'h00, a_rx_data;
    logic       a_tx_ready, a_rx_valid, a_busy, a_sclk, a_mosi, a_miso, a_cs_n;
    assign a_miso = loop_a ? a_mosi : slave_miso;

    logic        b_cpol = 1'b0, b_cpha = 1'b0, b_tx_valid = 1'b0;
    logic [15:0] b_tx_data = 16'h0000, b_rx_data;
    logic        b_tx_ready, b_rx_valid, b_busy, b_sclk, b_mosi, b_cs_n;

    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .LSB_FIRST(1'b0)) u_a (
        .clk(clk), .rst(rst), .cpol(a_cpol), .cpha(a_cpha), .tx_data(a_tx_data),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .busy(a_busy), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso), .cs_n(a_cs_n)
    );

    spi_master_param #(.DATA_W(16), .CLK_DIV(1), .LSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst(rst), .cpol(b_cpol), .cpha(b_cpha), .tx_data(b_tx_data),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .busy(b_busy), .sclk(b_sclk), .mosi(b_mosi), .miso(b_mosi), .cs_n(b_cs_n)
    );

    // Bus observers: cs_n run lengths, sclk edges, and a slave that samples/drives per CPHA
    logic       a_cs_prev = 1'b1, a_sclk_prev = 1'b0, a_cur_cpha = 1'b0;
    int         a_low_cnt = 0, a_high_cnt = 0, a_last_low = 0, a_last_high = 0, a_edges = 0, a_rises = 0;
    logic [7:0] s_rx = 8'h00, s_tx = 8'h00, slave_word = 8'h00;
    logic [7:0] a_rxq[$];

    always @(negedge clk) begin
        if (a_rx_valid) a_rxq.push_back(a_rx_data);
        if (a_cs_n) begin
            if (!a_cs_prev) begin
                a_last_low = a_low_cnt;
                a_high_cnt = 1;
            end else a_high_cnt++;
        end else if (a_cs_prev) begin
            a_last_high = a_high_cnt;
            a_low_cnt = 1;
            a_edges = 0;
            a_rises = 0;
            s_rx = 8'h00;
            s_tx = slave_word;
            if (!a_cur_cpha) begin
                slave_miso = s_tx[7];
                s_tx = s_tx << 1;
            end
        end else begin
            a_low_cnt++;
            if (a_sclk != a_sclk_prev) begin
                if (a_sclk) a_rises++;
                if (a_edges[0] == a_cur_cpha) s_rx = {s_rx[6:0], a_mosi};
                else begin
                    slave_miso = s_tx[7];
                    s_tx = s_tx << 1;
                end
                a_edges++;
            end
        end
        a_cs_prev = a_cs_n;
        a_sclk_prev = a_sclk;
    end

    logic        b_cs_prev = 1'b1, b_sclk_prev = 1'b0, b_cur_cpha = 1'b0;
    int          b_low_cnt = 0, b_last_low = 0, b_edges = 0;
    logic [15:0] b_bits = 16'h0000;

    always @(negedge clk) begin
        if (b_cs_n) begin
            if (!b_cs_prev) b_last_low = b_low_cnt;
        end else if (b_cs_prev) begin
            b_low_cnt = 1;
            b_edges = 0;
            b_bits = 16'h0000;
        end else begin
            b_low_cnt++;
            if (b_sclk != b_sclk_prev) begin
                if (b_edges[0] == b_cur_cpha) b_bits = {b_bits[14:0], b_mosi};
                b_edges++;
            end
        end
        b_cs_prev = b_cs_n;
        b_sclk_prev = b_sclk;
    end

    task automatic xfer_a(input logic [7:0] d, input logic pol, input logic pha, output logic ok);
        a_cpol = pol;
        a_cur_cpha = pha;
        repeat (3) @(negedge clk);
        a_tx_data = d;
        a_cpha = pha;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = a_rx_valid;
        end
        @(negedge clk);
    endtask

    task automatic xfer_b(input logic [15:0] d, input logic pol, input logic pha, output logic ok);
        b_cpol = pol;
        b_cur_cpha = pha;
        repeat (3) @(negedge clk);
        b_tx_data = d;
        b_cpha = pha;
        b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = b_rx_valid;
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15-i] = d[i];
        return r;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_tx_ready, a_busy, a_cs_n, a_sclk, a_mosi, a_rx_valid, a_rx_data} !== {6'b101000, 8'h00}) begin
            errors++;
            $display("FAIL reset_a got %b exp %b", {a_tx_ready, a_busy, a_cs_n, a_sclk, a_mosi, a_rx_valid, a_rx_data}, {6'b101000, 8'h00});
        end
        checks++;
        if ({b_tx_ready, b_busy, b_cs_n, b_sclk, b_mosi, b_rx_valid, b_rx_data} !== {6'b101000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_b got %b exp %b", {b_tx_ready, b_busy, b_cs_n, b_sclk, b_mosi, b_rx_valid, b_rx_data}, {6'b101000, 16'h0000});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic ok;
        int n0;
        loop_a = 1'b1;
        n0 = a_rxq.size();
        xfer_a(8'hA9, 1'b0, 1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL mode0_done got %b exp 1", ok); end
        checks++;
        if (a_last_low != 36) begin errors++; $display("FAIL mode0_cs_low got %0d exp 36", a_last_low); end
        checks++;
        if (a_rises != 8) begin errors++; $display("FAIL mode0_rises got %0d exp 8", a_rises); end
        checks++;
        if (s_rx !== 8'hA9) begin errors++; $display("FAIL mode0_mosi_bits got %h exp a9", s_rx); end
        checks++;
        if (a_rx_data !== 8'hA9) begin errors++; $display("FAIL mode0_rx got %h exp a9", a_rx_data); end
        checks++;
        if (a_rxq.size() != n0 + 1) begin errors++; $display("FAIL mode0_pulses got %0d exp %0d", a_rxq.size(), n0 + 1); end
    endtask

    task automatic test_modes();
        logic ok, pol, pha;
        loop_a = 1'b0;
        slave_word = 8'h5C;
        for (int m = 1; m < 4; m++) begin
            pol = m[1];
            pha = m[0];
            a_cpol = pol;
            repeat (3) @(negedge clk);
            checks++;
            if (a_sclk !== pol) begin errors++; $display("FAIL mode%0d_idle_before got %b exp %b", m, a_sclk, pol); end
            xfer_a(8'h3E, pol, pha, ok);
            checks++;
            if (s_rx !== 8'h3E) begin errors++; $display("FAIL mode%0d_slave_rx got %h exp 3e", m, s_rx); end
            checks++;
            if (a_rx_data !== 8'h5C || !ok) begin errors++; $display("FAIL mode%0d_master_rx got %h exp 5c", m, a_rx_data); end
            checks++;
            if (a_sclk !== pol) begin errors++; $display("FAIL mode%0d_idle_after got %b exp %b", m, a_sclk, pol); end
        end
        a_cpol = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_lsb_wide();
        logic ok;
        xfer_b(16'h8001, 1'b0, 1'b0, ok);
        checks++;
        if (b_bits !== 16'h8001 || !ok) begin errors++; $display("FAIL lsb_mosi_seq got %h exp 8001", b_bits); end
        checks++;
        if (b_last_low != 34) begin errors++; $display("FAIL lsb_cs_low got %0d exp 34", b_last_low); end
        checks++;
        if (b_rx_data !== 16'h8001) begin errors++; $display("FAIL lsb_rx got %h exp 8001", b_rx_data); end
    endtask

    task automatic test_back_to_back();
        int n0;
        logic seen;
        loop_a = 1'b1;
        a_cpol = 1'b0;
        a_cur_cpha = 1'b0;
        a_cpha = 1'b0;
        repeat (3) @(negedge clk);
        n0 = a_rxq.size();
        a_tx_data = 8'h12;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_data = 8'h34;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = a_rx_valid; end
        @(negedge clk);
        a_tx_valid = 1'b0;
        repeat (3) begin
            repeat (4) @(negedge clk);
            a_tx_valid = 1'b1;
            a_tx_data = 8'($urandom);
            a_cpol = 1'b1;
            @(negedge clk);
            a_tx_valid = 1'b0;
            a_cpol = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = a_rx_valid; end
        repeat (60) @(negedge clk);
        checks++;
        if (a_rxq.size() != n0 + 2) begin
            errors++;
            $display("FAIL b2b_count got %0d exp %0d", a_rxq.size() - n0, 2);
        end else begin
            checks++;
            if (a_rxq[n0] !== 8'h12) begin errors++; $display("FAIL b2b_first got %h exp 12", a_rxq[n0]); end
            checks++;
            if (a_rxq[n0+1] !== 8'h34) begin errors++; $display("FAIL b2b_second got %h exp 34", a_rxq[n0+1]); end
        end
        checks++;
        if (a_last_high != 1) begin errors++; $display("FAIL b2b_cs_gap got %0d exp 1", a_last_high); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int n0;
        loop_a = 1'b1;
        a_cpol = 1'b0;
        a_cur_cpha = 1'b0;
        a_cpha = 1'b0;
        repeat (3) @(negedge clk);
        n0 = a_rxq.size();
        a_tx_data = 8'h5A;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = a_edges >= 5; end
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_reach_e5 got %0d exp 5", a_edges); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_cs_n, a_sclk, a_tx_ready, a_busy} !== 4'b1010) begin
            errors++;
            $display("FAIL rstmid_async got %b exp 1010", {a_cs_n, a_sclk, a_tx_ready, a_busy});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (a_rxq.size() != n0) begin errors++; $display("FAIL rstmid_no_pulse got %0d exp 0", a_rxq.size() - n0); end
        xfer_a(8'hC3, 1'b0, 1'b0, ok);
        checks++;
        if (a_rx_data !== 8'hC3 || s_rx !== 8'hC3 || !ok) begin
            errors++;
            $display("FAIL rstmid_next got rx %h mosi %h exp c3", a_rx_data, s_rx);
        end
    endtask

    task automatic test_random();
        logic ok, pol, pha;
        logic [7:0] d8, w8;
        logic [15:0] d16;
        loop_a = 1'b0;
        for (int n = 0; n < 6; n++) begin
            d8 = 8'($urandom);
            w8 = 8'($urandom);
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            slave_word = w8;
            xfer_a(d8, pol, pha, ok);
            checks++;
            if (s_rx !== d8 || !ok) begin errors++; $display("FAIL rand_a_slave_rx got %h exp %h", s_rx, d8); end
            checks++;
            if (a_rx_data !== w8) begin errors++; $display("FAIL rand_a_master_rx got %h exp %h", a_rx_data, w8); end
            checks++;
            if (a_last_low != 36) begin errors++; $display("FAIL rand_a_cs_low got %0d exp 36", a_last_low); end
        end
        for (int n = 0; n < 6; n++) begin
            d16 = 16'($urandom);
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            xfer_b(d16, pol, pha, ok);
            checks++;
            if (b_rx_data !== d16 || !ok) begin errors++; $display("FAIL rand_b_rx got %h exp %h", b_rx_data, d16); end
            checks++;
            if (b_bits !== rev16(d16)) begin errors++; $display("FAIL rand_b_order got %h exp %h", b_bits, rev16(d16)); end
            checks++;
            if (b_last_low != 34) begin errors++; $display("FAIL rand_b_cs_low got %0d exp 34", b_last_low); end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_lsb_wide();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
